// File: rtl/store_merge_unit_pkg.sv
// Shared store decode constants, FSM state encoding and alignment helper
// for the store merge unit.
package store_merge_unit_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_SB     = 3'b000;
  localparam logic [2:0] F3_SH     = 3'b001;
  localparam logic [2:0] F3_SW     = 3'b010;
  localparam logic [2:0] F3_SD     = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_DONE
  } state_t;

  // Natural alignment check on the byte offset within the doubleword.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] off);
    case (funct3)
      F3_SH:   return off[0];
      F3_SW:   return |off[1:0];
      F3_SD:   return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Combinational byte-lane merge: overlays the store bytes onto the old
// doubleword at the given byte offset (little-endian).
module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [63:0] old_dword,
  input  logic [63:0] rs2_data,
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  output logic [63:0] merged
);

  logic [63:0] size_mask;
  logic [63:0] lane_mask;
  logic [5:0]  shamt;

  always_comb begin
    size_mask = '1;
    case (funct3)
      F3_SB:   size_mask = 64'h0000_0000_0000_00FF;
      F3_SH:   size_mask = 64'h0000_0000_0000_FFFF;
      F3_SW:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
  end

  assign shamt     = {offset, 3'b000};
  assign lane_mask = size_mask << shamt;
  assign merged    = (old_dword & ~lane_mask) | ((rs2_data << shamt) & lane_mask);

endmodule

// File: rtl/store_merge_unit.sv
// Store unit that turns sb/sh/sw into a doubleword read-merge-write and
// issues sd directly; illegal or misaligned stores complete with err.
module store_merge_unit
  import store_merge_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic [63:0] addr,
  input  logic [63:0] rs2_data,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] rs2_q;
  logic [63:0] wdata_q;
  logic        err_q;

  logic        accept;
  logic        legal;
  logic        bad;
  logic        is_sd;
  logic [63:0] merged;
  logic        unused_inst_bits;

  assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

  assign accept = start && (state_q == S_IDLE);
  assign legal  = (inst[6:0] == OPC_STORE) && !inst[14];
  assign bad    = !legal || is_misaligned(inst[14:12], addr[2:0]);
  assign is_sd  = (inst[14:12] == F3_SD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad)        state_d = S_DONE;
          else if (is_sd) state_d = S_WRITE;
          else            state_d = S_READ;
        end
      end
      S_READ:  state_d = S_MERGE;
      S_MERGE: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  store_lane_merge u_lane_merge (
    .old_dword (mem_rdata),
    .rs2_data  (rs2_q),
    .funct3    (funct3_q),
    .offset    (addr_q[2:0]),
    .merged    (merged)
  );

  // Read data is only valid during MERGE, so it is captured there and the
  // write data always comes from wdata_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q <= '0;
      addr_q   <= '0;
      rs2_q    <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      funct3_q <= inst[14:12];
      addr_q   <= addr;
      rs2_q    <= rs2_data;
      err_q    <= bad;
      if (!bad && is_sd) wdata_q <= rs2_data;
    end else if (state_q == S_MERGE) begin
      wdata_q <= merged;
    end
  end

  assign mem_addr  = {addr_q[63:3], 3'b000};
  assign mem_wdata = wdata_q;
  assign mem_re    = (state_q == S_READ);
  assign mem_we    = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done && err_q;

endmodule
